stepper_bank: RTL and testbench

Multi-channel step/direction pulse generator that replaces per-joint stepper instances with one parametrised bank. Each channel turns a signed period command from the SPI receive buffer into STP/DIR pulses, applying a minimum pulse width, a direction-setup delay and per-channel direction inversion. Each channel also returns a signed 32-bit step-position feedback for the transmit buffer. It sits between the SPI slave's unpacked command words and the board STP/DIR pins.

---
 rtl/stepper_bank.sv | 176 +++++++++++++++++
 tb/tb_stepper_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stepper_bank.sv
// Bank of independent step/direction pulse generators with per-channel position feedback.
// Define STEPPER_BANK_DIRSETUP_EN to hold DIR stable for DIR_SETUP cycles before stepping after a reversal.

module stepper_chan #(
    parameter int PULSE_LEN = 48,
    parameter int DIR_SETUP = 96
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic [31:0] cmd,
    output logic        stp,
    output logic        dir,
    output logic [31:0] feedback
);

`ifdef STEPPER_BANK_DIRSETUP_EN
    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    localparam logic [31:0] MIN_P = 32'(2 * PULSE_LEN);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);

    state_t        state, state_nxt;
    logic [31:0]   mag, p_eff, cnt, period;
    logic [PW-1:0] pcnt;
    logic          nz, want, boundary;
    logic          cnt_clr, load_p, load_dir, do_step;

    // -2^31 has no positive counterpart; clamp it to the largest period
    assign mag      = cmd[31] ? ((cmd == 32'h8000_0000) ? 32'h7FFF_FFFF : -cmd) : cmd;
    assign p_eff    = (mag < MIN_P) ? MIN_P : mag;
    assign nz       = |cmd;
    assign want     = ~cmd[31];
    assign boundary = (state == RUN) && (cnt == period - 32'd1);

`ifndef STEPPER_BANK_DIRSETUP_EN
    logic unused_setup;
    assign unused_setup = (DIR_SETUP != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        load_p    = 1'b0;
        load_dir  = 1'b0;
        do_step   = 1'b0;
        if (!active) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (nz) begin
                        if (want == dir) begin
                            state_nxt = RUN;
                            load_p    = 1'b1;
                        end else begin
                            load_dir = 1'b1;
`ifdef STEPPER_BANK_DIRSETUP_EN
                            state_nxt = SETUP;
`else
                            state_nxt = RUN;
                            load_p    = 1'b1;
`endif
                        end
                    end
                end
`ifdef STEPPER_BANK_DIRSETUP_EN
                SETUP: begin
                    if (cnt == 32'(DIR_SETUP - 1)) begin
                        state_nxt = RUN;
                        cnt_clr   = 1'b1;
                        load_p    = 1'b1;
                    end
                end
`endif
                RUN: begin
                    if (boundary) begin
                        cnt_clr = 1'b1;
                        load_p  = 1'b1;
                        if (!nz) begin
                            state_nxt = IDLE;
                        end else if (want != dir) begin
                            load_dir = 1'b1;
`ifdef STEPPER_BANK_DIRSETUP_EN
                            state_nxt = SETUP;
`endif
                        end else begin
                            do_step = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            period   <= MIN_P;
            dir      <= 1'b0;
            feedback <= '0;
        end else begin
            cnt <= cnt_clr ? 32'd0 : cnt + 32'd1;
            if (load_p)   period <= p_eff;
            if (load_dir) dir    <= want;
            if (do_step)  feedback <= feedback + (dir ? 32'd1 : 32'hFFFF_FFFF);
        end
    end

    // Pulse timer; deactivation truncates an in-flight pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stp  <= 1'b0;
            pcnt <= '0;
        end else if (!active) begin
            stp  <= 1'b0;
            pcnt <= '0;
        end else if (do_step) begin
            stp  <= 1'b1;
            pcnt <= PULSE_LAST;
        end else if (stp) begin
            if (pcnt == '0) stp  <= 1'b0;
            else            pcnt <= pcnt - PW'(1);
        end
    end

endmodule

module stepper_bank #(
    parameter int                  CHANNELS   = 5,
    parameter int                  PULSE_LEN  = 48,
    parameter int                  DIR_SETUP  = 96,
    parameter logic [CHANNELS-1:0] DIR_INVERT = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    error,
    input  logic [CHANNELS-1:0]     enable,
    input  logic [32*CHANNELS-1:0]  freq_cmd,
    output logic [32*CHANNELS-1:0]  feedback,
    output logic [CHANNELS-1:0]     stp,
    output logic [CHANNELS-1:0]     dir
);

    logic [CHANNELS-1:0] dir_log;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        stepper_chan #(
            .PULSE_LEN (PULSE_LEN),
            .DIR_SETUP (DIR_SETUP)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .active   (enable[i] & ~error),
            .cmd      (freq_cmd[32*i +: 32]),
            .stp      (stp[i]),
            .dir      (dir_log[i]),
            .feedback (feedback[32*i +: 32])
        );
    end

    assign dir = dir_log ^ DIR_INVERT;

endmodule

// File: tb/tb_stepper_bank.sv
// Scoreboard bench for stepper_bank: timestamp-based reference model pushes expected pin state each edge.
module tb_stepper_bank;
    localparam int CH = 2;
    localparam int PL = 4;
    localparam int DS = 8;
    localparam logic [CH-1:0] INV = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              error = 1'b0;
    logic [CH-1:0]     enable = '0;
    logic [32*CH-1:0]  freq_cmd = '0;
    logic [32*CH-1:0]  feedback;
    logic [CH-1:0]     stp;
    logic [CH-1:0]     dir;

    stepper_bank #(
        .CHANNELS   (CH),
        .PULSE_LEN  (PL),
        .DIR_SETUP  (DS),
        .DIR_INVERT (INV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .error    (error),
        .enable   (enable),
        .freq_cmd (freq_cmd),
        .feedback (feedback),
        .stp      (stp),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0]    stp;
        logic [CH-1:0]    dir;
        logic [32*CH-1:0] fb;
    } snap_t;

    snap_t exp_q[$];
    int    passed = 0;
    int    total  = 0;

    // Reference model: 0 idle, 1 direction setup, 2 running; events stamped by edge index
    int          mode  [CH];
    bit          ldir  [CH];
    bit          mstp  [CH];
    logic [31:0] mfb   [CH];
    longint      start [CH];
    longint      per   [CH];
    longint      pend  [CH];
    longint      cyc = 0;

    function automatic longint eff_p(input logic [31:0] c);
        longint m;
        m = longint'($signed(c));
        if (m < 0) m = -m;
        if (m > 64'sh7FFF_FFFF) m = 64'sh7FFF_FFFF;
        if (m < 2 * PL) m = 2 * PL;
        return m;
    endfunction

    always @(posedge clk) begin : model
        snap_t s;
        for (int i = 0; i < CH; i++) begin
            logic [31:0] c;
            bit act, want;
            c    = freq_cmd[32*i +: 32];
            act  = enable[i] && !error;
            want = !c[31];
            if (rst) begin
                mode[i] = 0; ldir[i] = 0; mstp[i] = 0; mfb[i] = '0;
                start[i] = 0; per[i] = 0; pend[i] = 0;
            end else if (!act) begin
                mode[i] = 0; mstp[i] = 0;
            end else begin
                if (mstp[i] && cyc == pend[i]) mstp[i] = 0;
                case (mode[i])
                    0: if (c != 0) begin
                        if (want == ldir[i]) begin
                            mode[i] = 2; start[i] = cyc; per[i] = eff_p(c);
                        end else begin
                            ldir[i] = want; start[i] = cyc;
`ifdef STEPPER_BANK_DIRSETUP_EN
                            mode[i] = 1;
`else
                            mode[i] = 2; per[i] = eff_p(c);
`endif
                        end
                    end
                    1: if (cyc - start[i] == DS) begin
                        mode[i] = 2; start[i] = cyc; per[i] = eff_p(c);
                    end
                    default: if (cyc - start[i] == per[i]) begin
                        start[i] = cyc; per[i] = eff_p(c);
                        if (c == 0) begin
                            mode[i] = 0;
                        end else if (want != ldir[i]) begin
                            ldir[i] = want;
`ifdef STEPPER_BANK_DIRSETUP_EN
                            mode[i] = 1;
`endif
                        end else begin
                            mstp[i] = 1; pend[i] = cyc + PL;
                            mfb[i] = mfb[i] + (ldir[i] ? 32'd1 : 32'hFFFF_FFFF);
                        end
                    end
                endcase
            end
            s.stp[i] = mstp[i];
            s.dir[i] = ldir[i] ^ INV[i];
            s.fb[32*i +: 32] = mfb[i];
        end
        exp_q.push_back(s);
        cyc++;
    end

    always @(negedge clk) begin : monitor
        snap_t e;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard_underflow t=%0t: no expected entry", $time);
        end else begin
            e = exp_q.pop_front();
            if (!rst) begin
                total++;
                if ({stp, dir, feedback} === {e.stp, e.dir, e.fb}) passed++;
                else $display("FAIL pins t=%0t stp=%b want %b dir=%b want %b fb=%h want %h",
                              $time, stp, e.stp, dir, e.dir, feedback, e.fb);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cmd(input int i, input logic [31:0] v);
        freq_cmd[32*i +: 32] = v;
    endtask

    task automatic wait_stp(input int i, input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (stp[i]) seen = 1;
        end
        total++;
        if (seen) passed++;
        else $display("FAIL wait_stp ch%0d: stp stayed 0 for %0d cycles, required 1", i, budget);
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'($urandom_range(1, 12));
            2: v = 32'($urandom_range(8, 40));
            3: v = -32'($urandom_range(1, 40));
            4: v = 32'h8000_0000;
            default: v = 32'h7FFF_FFFF;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        run(100);

        enable = 2'b01; set_cmd(0, 32'd20);
        run(100);
        set_cmd(0, 32'd3);
        run(60);
        set_cmd(0, -32'sd20);
        run(100);

        wait_stp(0, 200);
        error = 1'b1;
        run(5);
        error = 1'b0;
        run(60);

        enable = 2'b11; set_cmd(1, 32'h8000_0000);
        run(10000);

        repeat (40) begin
            enable = CH'($urandom);
            error  = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < CH; i++) set_cmd(i, rand_cmd());
            run($urandom_range(1, 80));
        end

        enable = 2'b01; error = 1'b0; set_cmd(0, 32'd12); set_cmd(1, 32'd0);
        wait_stp(0, 500);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (stp === '0 && feedback === '0) passed++;
        else $display("FAIL async_reset: stp=%b fb=%h, required 0 and 0", stp, feedback);
        @(posedge clk);
        #2 rst = 1'b0;
        run(50);

        run(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
